multicast_dispatch: RTL
=======================

Name: multicast_dispatch

Overview:
- Sequencer that sits behind the multi-address decoder and turns one multicast request into a serial series of unicast transfers, one per set bit of the decoded mask.
- Accepts a request together with the decoder's `mask`/`dec_error` outputs and latches them.
- Issues the payload to each selected target index in ascending order over a valid/ready channel.
- Returns a single completion response (error flag plus target count) once every target has accepted.

Parameters:
- NoIndices, 4, number of targets; width of the mask; must be >= 1.
- DataWidth, 32, payload width in bits.
- IdxWidth, (NoIndices > 1) ? $clog2(NoIndices) : 1, width of the target index output.
- CntWidth, $clog2(NoIndices+1), width of the target count in the response.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request ready; high only in IDLE.
- req_data_i  input  DataWidth  request payload.
- req_mask_i  input  NoIndices  decoded target mask, from the decoder `mask_o`.
- req_dec_error_i  input  1  decode error, from the decoder `dec_error_o`.
- out_valid_o  output  1  unicast transfer valid.
- out_ready_i  input  1  unicast transfer ready from the selected target.
- out_idx_o  output  IdxWidth  target index of the current transfer.
- out_data_o  output  DataWidth  latched payload.
- rsp_valid_o  output  1  completion response valid.
- rsp_ready_i  input  1  completion response ready.
- rsp_err_o  output  1  request had a decode error or an empty mask.
- rsp_cnt_o  output  CntWidth  number of targets served.

Behaviour:
- FSM states: IDLE, ISSUE, RSP. Registers: state, pend_mask, data_q, err_q, cnt_q.
- Reset: on a clk_i edge with rst_ni=0, state<=IDLE and pend_mask, data_q, err_q, cnt_q <= 0. Reset is not sampled asynchronously.
- Outputs immediately after reset: req_ready_o=1, out_valid_o=0, out_idx_o=0, out_data_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_cnt_o=0.
- Reset asserted mid-operation aborts the transaction; no response is produced for it.
- Output decoding (combinational from state and registers only):
  - req_ready_o = (state==IDLE).
  - out_valid_o = (state==ISSUE).
  - rsp_valid_o = (state==RSP).
  - out_idx_o = index of the lowest set bit of pend_mask; 0 when pend_mask==0.
  - out_data_o = data_q; rsp_err_o = err_q; rsp_cnt_o = cnt_q.
- There is no combinational path from req_* inputs to any output.
- IDLE: on req_valid_i & req_ready_o:
  - data_q<=req_data_i, cnt_q<=0.
  - If req_dec_error_i=1 or req_mask_i==0: err_q<=1, pend_mask<=0, go to RSP. An asserted error overrides a non-zero mask.
  - Otherwise: err_q<=0, pend_mask<=req_mask_i, go to ISSUE.
- ISSUE: out_valid_o held high with out_idx_o/out_data_o stable until out_ready_i.
  - On handshake: clear the lowest set bit of pend_mask and increment cnt_q.
  - If that was the last set bit, go to RSP in the same edge; otherwise stay in ISSUE and present the next index on the next cycle.
  - out_valid_o is never deasserted without a handshake.
- RSP: rsp_valid_o held until rsp_ready_i; on handshake go to IDLE.
  - The next request can be accepted no earlier than the cycle after the response handshake. There is no overlap; one request is in flight at a time.
- Latency: request accepted at edge T → first out_valid_o in cycle T+1.
  - With out_ready_i tied high and N mask bits set, rsp_valid_o is asserted in cycle T+1+N.
  - For an error or empty mask, rsp_valid_o is asserted in cycle T+1.
- Width rules:
  - cnt_q saturation is impossible; the maximum value NoIndices fits CntWidth.
  - For NoIndices=1, out_idx_o is constant 0.
- Inputs are ignored when not in IDLE; req_mask_i may change freely after acceptance.

Test Plan:
- Reset: hold rst_ni=0 for 3 edges with req_valid_i=1 → req_ready_o=1, out_valid_o=0, rsp_valid_o=0 throughout; no request is accepted during reset.
- Multicast, NoIndices=4: mask=4'b1010, data=0xDEADBEEF, out_ready_i=1 → out_idx_o=1 then 3 on consecutive cycles, both carrying 0xDEADBEEF; rsp_valid_o 3 cycles after acceptance with rsp_cnt_o=2, rsp_err_o=0.
- Backpressure: mask=4'b0101, out_ready_i low for 4 cycles on idx 0 → out_valid_o, out_idx_o=0 and data remain stable; idx 2 is issued only after the handshake; rsp_cnt_o=2.
- Decode error: req_dec_error_i=1 with mask=4'b0001 → no out_valid_o; rsp_valid_o next cycle with rsp_err_o=1, rsp_cnt_o=0. Repeat with mask=0 and dec_error=0 → same response.
- Response stall and back-to-back requests: hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 → req_ready_o=0 while stalled; the second request (mask=4'b1111) is accepted the cycle after the response handshake and yields idx 0,1,2,3, rsp_cnt_o=4.
- Reset mid-ISSUE: after idx 0 of mask 4'b1111 is accepted, pulse rst_ni=0 for one edge → state IDLE, out_valid_o=0, no response for the aborted request; the next request completes normally.

Source files
------------

// File: rtl/multicast_dispatch.sv
// Serialises one decoded multicast request into ascending-index unicast transfers,
// then returns a single completion response carrying the error flag and target count.
module multicast_dispatch #(
    parameter int unsigned NoIndices = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1,
    parameter int unsigned CntWidth  = $clog2(NoIndices + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [NoIndices-1:0] req_mask_i,
    input  logic                 req_dec_error_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdxWidth-1:0]  out_idx_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_err_o,
    output logic [CntWidth-1:0]  rsp_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StRsp   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NoIndices-1:0] pend_mask_q, pend_mask_d, pend_rest;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [IdxWidth-1:0]  low_idx;

    // Downward scan so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = NoIndices - 1; i >= 0; i--) begin
            if (pend_mask_q[i]) begin
                low_idx = IdxWidth'(i);
            end
        end
    end

    assign pend_rest = pend_mask_q & (pend_mask_q - NoIndices'(1));

    always_comb begin
        state_d     = state_q;
        pend_mask_d = pend_mask_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    data_d = req_data_i;
                    cnt_d  = '0;
                    if (req_dec_error_i || (req_mask_i == '0)) begin
                        err_d       = 1'b1;
                        pend_mask_d = '0;
                        state_d     = StRsp;
                    end else begin
                        err_d       = 1'b0;
                        pend_mask_d = req_mask_i;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                if (out_ready_i) begin
                    pend_mask_d = pend_rest;
                    cnt_d       = cnt_q + CntWidth'(1);
                    if (pend_rest == '0) begin
                        state_d = StRsp;
                    end
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pend_mask_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_mask_q <= pend_mask_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign out_valid_o = (state_q == StIssue);
    assign rsp_valid_o = (state_q == StRsp);
    assign out_idx_o   = low_idx;
    assign out_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign rsp_cnt_o   = cnt_q;

endmodule
